// File: rtl/far_path_adder_if.sv
// Operand/result handshake bundle for the far-path mantissa adder.
// The master side issues operands and accepts results; the slave is the adder itself.
interface far_path_adder_if #(
    parameter int unsigned size_in_mantissa  = 24,
    parameter int unsigned size_out_mantissa = 24,
    parameter int unsigned size_exponent     = 8
);
    logic                         in_valid;
    logic                         in_ready;
    logic [size_in_mantissa-1:0]  m_a_number;
    logic [size_in_mantissa-1:0]  m_b_number;
    logic [size_exponent-1:0]     exp_a;
    logic [size_exponent-1:0]     exp_difference;
    logic                         eff_sub;
    logic                         out_valid;
    logic                         out_ready;
    logic [size_out_mantissa-1:0] resulted_m_o;
    logic [size_exponent-1:0]     resulted_e_o;
    logic                         ovf;

    modport master (
        output in_valid, m_a_number, m_b_number, exp_a, exp_difference, eff_sub, out_ready,
        input  in_ready, out_valid, resulted_m_o, resulted_e_o, ovf
    );

    modport slave (
        input  in_valid, m_a_number, m_b_number, exp_a, exp_difference, eff_sub, out_ready,
        output in_ready, out_valid, resulted_m_o, resulted_e_o, ovf
    );
endinterface

// File: rtl/far_path_adder.sv
// Far-path mantissa add/subtract (|Ea-Eb| >= 2): align with G/R/S, add/sub, one-step normalize, RNE round.
// Three pipeline stages (align, add, normalize+round) that shift together under a valid/ready handshake.
module far_path_adder #(
    parameter int unsigned size_in_mantissa  = 24,
    parameter int unsigned size_out_mantissa = 24,
    parameter int unsigned size_exponent     = 8,
    parameter int unsigned size_counter      = 5
) (
    input logic              clk,
    input logic              rst,
    far_path_adder_if.slave  bus
);
    localparam int unsigned man_w = size_in_mantissa;
    localparam int unsigned aln_w = man_w + 3;
    localparam int unsigned sum_w = man_w + 4;
    localparam int unsigned exp_w = size_exponent + 1;
    localparam int unsigned rnd_w = man_w + 1;
    localparam logic [exp_w-1:0] ovf_lim = {1'b0, {size_exponent{1'b1}}};

    logic advance;

    // stage 1 registers
    logic             s1_valid;
    logic [man_w-1:0] s1_ma;
    logic [aln_w-1:0] s1_b;
    logic [exp_w-1:0] s1_exp;
    logic             s1_sub;

    // stage 2 registers
    logic             s2_valid;
    logic [sum_w-1:0] s2_sum;
    logic [exp_w-1:0] s2_exp;

    // combinational stage logic
    logic [aln_w-1:0]        b_ext;
    logic [aln_w-1:0]        b_shift;
    logic [aln_w-1:0]        lost_mask;
    logic [aln_w-1:0]        b_aligned;
    logic [size_counter-1:0] shamt;
    logic                    far_out;
    logic [sum_w-1:0]        sum_c;
    logic [man_w-1:0]        n_man;
    logic                    g_bit;
    logic                    r_bit;
    logic                    s_bit;
    logic [exp_w-1:0]        n_exp;
    logic                    round_up;
    logic [rnd_w-1:0]        rnd;
    logic [man_w-1:0]        f_man;
    logic [exp_w-1:0]        f_exp;
    logic                    f_ovf;

    // a held result blocks the whole pipeline; otherwise everything moves
    assign advance      = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = advance;

    // align: shift B right into a G/R/S-extended field, folding shifted-out bits into bit 0
    always_comb begin
        b_ext     = {bus.m_b_number, 3'b000};
        far_out   = bus.exp_difference >= size_exponent'(aln_w);
        shamt     = far_out ? '0 : size_counter'(bus.exp_difference);
        b_shift   = b_ext >> shamt;
        lost_mask = ~({aln_w{1'b1}} << shamt);
        if (far_out) begin
            b_aligned = {{(aln_w-1){1'b0}}, |bus.m_b_number};
        end else begin
            b_aligned = {b_shift[aln_w-1:1], b_shift[0] | (|(b_ext & lost_mask))};
        end
    end

    // add/sub with one headroom bit; diff >= 2 keeps subtraction non-negative
    always_comb begin
        if (s1_sub) begin
            sum_c = {1'b0, s1_ma, 3'b000} - {1'b0, s1_b};
        end else begin
            sum_c = {1'b0, s1_ma, 3'b000} + {1'b0, s1_b};
        end
    end

    // normalize by at most one position, then round to nearest-even
    always_comb begin
        n_man = s2_sum[sum_w-2:3];
        g_bit = s2_sum[2];
        r_bit = s2_sum[1];
        s_bit = s2_sum[0];
        n_exp = s2_exp;
        if (s2_sum[sum_w-1]) begin
            n_man = s2_sum[sum_w-1:4];
            g_bit = s2_sum[3];
            r_bit = s2_sum[2];
            s_bit = |s2_sum[1:0];
            n_exp = s2_exp + exp_w'(1);
        end else if (!s2_sum[sum_w-2]) begin
            n_man = s2_sum[sum_w-3:2];
            g_bit = s2_sum[1];
            r_bit = s2_sum[0];
            s_bit = 1'b0;
            n_exp = s2_exp - exp_w'(1);
        end

        round_up = g_bit & (r_bit | s_bit | n_man[0]);
        rnd      = {1'b0, n_man} + rnd_w'(round_up);
        f_man    = rnd[man_w-1:0];
        f_exp    = n_exp;
        if (rnd[man_w]) begin
            f_man = {1'b1, {(man_w-1){1'b0}}};
            f_exp = n_exp + exp_w'(1);
        end
        f_ovf = f_exp >= ovf_lim;
    end

    // pipeline registers; reset discards anything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid         <= 1'b0;
            s1_ma            <= '0;
            s1_b             <= '0;
            s1_exp           <= '0;
            s1_sub           <= 1'b0;
            s2_valid         <= 1'b0;
            s2_sum           <= '0;
            s2_exp           <= '0;
            bus.out_valid    <= 1'b0;
            bus.resulted_m_o <= '0;
            bus.resulted_e_o <= '0;
            bus.ovf          <= 1'b0;
        end else if (advance) begin
            s1_valid         <= bus.in_valid;
            s1_ma            <= bus.m_a_number;
            s1_b             <= b_aligned;
            s1_exp           <= {1'b0, bus.exp_a};
            s1_sub           <= bus.eff_sub;
            s2_valid         <= s1_valid;
            s2_sum           <= sum_c;
            s2_exp           <= s1_exp;
            bus.out_valid    <= s2_valid;
            bus.resulted_m_o <= size_out_mantissa'(f_man);
            bus.resulted_e_o <= f_exp[size_exponent-1:0];
            bus.ovf          <= f_ovf;
        end
    end
endmodule

// File: tb/tb_far_path_adder.sv
// Scoreboard bench for far_path_adder: directed vectors, backpressure, reset flush and random traffic
// checked against an arithmetic reference model.
module tb_far_path_adder;
    typedef struct packed {
        logic [23:0] m;
        logic [7:0]  e;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ready_mode = 1;
    res_t exp_q[$];

    far_path_adder_if #(.size_in_mantissa(24), .size_out_mantissa(24), .size_exponent(8)) bus ();

    far_path_adder #(
        .size_in_mantissa(24), .size_out_mantissa(24), .size_exponent(8), .size_counter(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // reference: exact integer arithmetic on the aligned/extended values
    function automatic res_t model(input logic [23:0] ma, input logic [23:0] mb,
                                   input logic [7:0] ea, input logic [7:0] diff, input logic sub);
        res_t   r;
        longint a8   = longint'(ma) * 8;
        longint b8   = longint'(mb) * 8;
        longint d    = longint'(diff);
        longint bal, s, t, keep;
        int     e    = int'(ea);
        bit     g, rr, st;
        if (d >= 27) begin
            bal = (mb != 0) ? 1 : 0;
        end else begin
            bal = b8 / (longint'(1) << d);
            if ((b8 % (longint'(1) << d)) != 0) bal = bal | 1;
        end
        s = sub ? a8 - bal : a8 + bal;
        if (s >= (longint'(1) << 27)) begin
            keep = s / 16; g = (s % 16) >= 8; rr = (s % 8) >= 4; st = (s % 4) != 0;
            e = e + 1;
        end else if (s < (longint'(1) << 26)) begin
            t = s * 2;
            keep = t / 8; g = (t % 8) >= 4; rr = (t % 4) >= 2; st = (t % 2) != 0;
            e = e - 1;
        end else begin
            keep = s / 8; g = (s % 8) >= 4; rr = (s % 4) >= 2; st = (s % 2) != 0;
        end
        if (g && (rr || st || (keep % 2) == 1)) keep = keep + 1;
        if (keep == (longint'(1) << 24)) begin
            keep = longint'(1) << 23;
            e = e + 1;
        end
        r.m   = 24'(keep);
        r.e   = 8'(e);
        r.ovf = (e >= 255);
        return r;
    endfunction

    // drive one operand set, hold until accepted, record its expected result
    task automatic send(input logic [23:0] ma, input logic [23:0] mb, input logic [7:0] ea,
                        input logic [7:0] diff, input logic sub, input res_t expv);
        int  waited = 0;
        bit  done   = 0;
        @(posedge clk); #1;
        bus.m_a_number     = ma;
        bus.m_b_number     = mb;
        bus.exp_a          = ea;
        bus.exp_difference = diff;
        bus.eff_sub        = sub;
        bus.in_valid       = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(expv);
                done = 1;
            end else begin
                waited++;
                if (waited > 200) begin
                    n_checks++; n_fail++;
                    $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
                    done = 1;
                end else begin
                    @(posedge clk);
                end
            end
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("drain_pending", longint'(exp_q.size()), 0);
    endtask

    // out_ready driver: 0 = held low, 1 = held high, 2 = random
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            case (ready_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // monitor: every output handshake pops and compares the oldest expectation
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_output: got m=0x%0h with no result pending", bus.resulted_m_o);
                end else begin
                    r = exp_q.pop_front();
                    check("out_m",   longint'(bus.resulted_m_o), longint'(r.m));
                    check("out_e",   longint'(bus.resulted_e_o), longint'(r.e));
                    check("out_ovf", longint'(bus.ovf),          longint'(r.ovf));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] ma, mb;
        logic [7:0]  ea, diff;
        logic        sub;
        int          cyc;
        bit          seen;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.m_a_number = '0; bus.m_b_number = '0;
        bus.exp_a = '0; bus.exp_difference = '0; bus.eff_sub = 1'b0;
        ready_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", longint'(bus.out_valid),    0);
        check("rst_m",         longint'(bus.resulted_m_o), 0);
        check("rst_e",         longint'(bus.resulted_e_o), 0);
        check("rst_ovf",       longint'(bus.ovf),          0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", longint'(bus.in_ready), 1);

        // latency: driven after edge P0, accepted at P1, visible after P3
        @(posedge clk); #1;
        bus.m_a_number = 24'h800000; bus.m_b_number = 24'h800000;
        bus.exp_a = 8'd127; bus.exp_difference = 8'd2; bus.eff_sub = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("lat_in_ready", longint'(bus.in_ready), 1);
        exp_q.push_back('{m: 24'hA00000, e: 8'd127, ovf: 1'b0});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        cyc = 1; seen = 0;
        while (!seen && cyc < 10) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
            else begin
                @(posedge clk);
                cyc++;
            end
        end
        check("latency_cycles", longint'(cyc), 3);
        wait_drain();

        // directed vectors
        send(24'h800000, 24'h800000, 8'd127, 8'd2,  1'b1, '{m: 24'hC00000, e: 8'd126, ovf: 1'b0});
        send(24'hFFFFFF, 24'h800000, 8'd127, 8'd2,  1'b0, '{m: 24'h900000, e: 8'd128, ovf: 1'b0});
        send(24'h800000, 24'h800001, 8'd127, 8'd25, 1'b0, '{m: 24'h800000, e: 8'd127, ovf: 1'b0});
        send(24'hFFFFFF, 24'h800000, 8'd254, 8'd2,  1'b0, '{m: 24'h900000, e: 8'd255, ovf: 1'b1});
        send(24'h800000, 24'hFFFFFF, 8'd200, 8'd40, 1'b0, '{m: 24'h800000, e: 8'd200, ovf: 1'b0});
        idle();
        wait_drain();

        // backpressure: three fill the pipe, the fourth waits, output holds
        ready_mode = 0;
        repeat (2) @(posedge clk);
        send(24'h800000, 24'h800000, 8'd127, 8'd2,  1'b0, '{m: 24'hA00000, e: 8'd127, ovf: 1'b0});
        send(24'h800000, 24'h800000, 8'd127, 8'd2,  1'b1, '{m: 24'hC00000, e: 8'd126, ovf: 1'b0});
        send(24'hFFFFFF, 24'h800000, 8'd127, 8'd2,  1'b0, '{m: 24'h900000, e: 8'd128, ovf: 1'b0});
        @(posedge clk); #1;
        bus.m_a_number = 24'h800000; bus.m_b_number = 24'h800001;
        bus.exp_a = 8'd127; bus.exp_difference = 8'd25; bus.eff_sub = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready",  longint'(bus.in_ready),     0);
            check("bp_out_valid", longint'(bus.out_valid),    1);
            check("bp_hold_m",    longint'(bus.resulted_m_o), 64'hA00000);
            @(posedge clk); #1;
        end
        ready_mode = 1;
        @(negedge clk);
        check("bp_release_in_ready", longint'(bus.in_ready), 1);
        exp_q.push_back('{m: 24'h800000, e: 8'd127, ovf: 1'b0});
        idle();
        wait_drain();

        // reset with a full pipeline drops everything in flight
        ready_mode = 0;
        repeat (2) @(posedge clk);
        for (int k = 0; k < 3; k++)
            send(24'h800000, 24'h800000, 8'd100, 8'd3, 1'b0, model(24'h800000, 24'h800000, 8'd100, 8'd3, 1'b0));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_valid", longint'(bus.out_valid),    0);
        check("midrst_m",         longint'(bus.resulted_m_o), 0);
        check("midrst_e",         longint'(bus.resulted_e_o), 0);
        check("midrst_ovf",       longint'(bus.ovf),          0);
        exp_q.delete();
        rst = 1'b0;
        ready_mode = 1;
        @(negedge clk);
        check("midrst_in_ready", longint'(bus.in_ready), 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("midrst_no_stale", longint'(bus.out_valid), 0);
        end

        // random traffic with random backpressure
        ready_mode = 2;
        for (int n = 0; n < 400; n++) begin
            ea   = 8'($urandom_range(2, 254));
            diff = 8'($urandom_range(2, 34));
            if (diff > ea) diff = ea;
            ma   = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : (24'h800000 | 24'($urandom));
            mb   = 24'h800000 | 24'($urandom);
            sub  = 1'($urandom);
            send(ma, mb, ea, diff, sub, model(ma, mb, ea, diff, sub));
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        ready_mode = 1;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
